// File: rtl/ghostbus_host_pkg.sv
// rtl/ghostbus_host_pkg.sv - shared types and helpers for the ghostbus host initiator
package ghostbus_host_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RBURST
    } state_t;

    // Width able to hold 0..depth, used for the credit and occupancy counters.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ghostbus_rsp_fifo.sv
// rtl/ghostbus_rsp_fifo.sv - first-word-fall-through response FIFO with occupancy count
module ghostbus_rsp_fifo
    import ghostbus_host_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 8,
    localparam int CW   = credit_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/ghostbus_host.sv
// rtl/ghostbus_host.sv - ghostbus initiator: command bursts in, bus cycles out, read data back
module ghostbus_host
    import ghostbus_host_pkg::*;
#(
    parameter int AW        = 24,
    parameter int DW        = 32,
    parameter int LW        = 8,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_wdata,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_din,
    output logic          busy
);

    localparam int CW = credit_w(RSP_DEPTH);

    state_t           state;
    logic [AW-1:0]    nxt_addr;
    logic [LW-1:0]    rem;
    logic             rd_last_q;
    logic [RD_LAT-1:0] sr_vld;
    logic [RD_LAT-1:0] sr_last;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic [DW:0]      fifo_rdata;
    logic [CW:0]      inflight;
    logic             credit;
    logic             issue_rd;
    logic             tap;

    // Count everything already committed to the FIFO so a returning sample always has a slot.
    assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit   = inflight < (CW+1)'(RSP_DEPTH);
    assign issue_rd = (state == RBURST) && credit;
    assign tap      = sr_vld[RD_LAT-1];

    // rem holds beats still to issue in WBURST, but beats-minus-one in RBURST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nxt_addr  <= '0;
            rem       <= '0;
            rd_last_q <= 1'b0;
            gb_addr   <= '0;
            gb_dout   <= '0;
            gb_we     <= 1'b0;
            gb_re     <= 1'b0;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
        end else begin
            gb_we     <= 1'b0;
            gb_re     <= 1'b0;
            rd_last_q <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        rem <= cmd_len;
                        if (cmd_we) begin
                            gb_we    <= 1'b1;
                            gb_addr  <= cmd_addr;
                            gb_dout  <= cmd_wdata;
                            nxt_addr <= cmd_addr + 1'b1;
                            if (cmd_len != '0) begin
                                state     <= WBURST;
                                cmd_ready <= 1'b0;
                                wr_ready  <= 1'b1;
                            end
                        end else begin
                            nxt_addr  <= cmd_addr;
                            state     <= RBURST;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                WBURST: begin
                    if (wr_valid) begin
                        gb_we    <= 1'b1;
                        gb_addr  <= nxt_addr;
                        gb_dout  <= wr_data;
                        nxt_addr <= nxt_addr + 1'b1;
                        rem      <= rem - 1'b1;
                        if (rem == LW'(1)) begin
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                RBURST: begin
                    if (issue_rd) begin
                        gb_re     <= 1'b1;
                        rd_last_q <= (rem == '0);
                        gb_addr   <= nxt_addr;
                        nxt_addr  <= nxt_addr + 1'b1;
                        rem       <= rem - 1'b1;
                        if (rem == '0) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_vld      <= '0;
            sr_last     <= '0;
            outstanding <= '0;
        end else begin
            sr_vld[0]  <= gb_re;
            sr_last[0] <= rd_last_q;
            for (int i = 1; i < RD_LAT; i++) begin
                sr_vld[i]  <= sr_vld[i-1];
                sr_last[i] <= sr_last[i-1];
            end
            case ({issue_rd, tap})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    ghostbus_rsp_fifo #(
        .W     (DW + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tap),
        .wdata ({sr_last[RD_LAT-1], gb_din}),
        .pop   (rsp_valid && rsp_ready),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_rdata[DW-1:0];
    assign rsp_last  = rsp_valid && fifo_rdata[DW];
    assign busy      = (state != IDLE) || (outstanding != '0) || !fifo_empty;

endmodule

// File: tb/tb_ghostbus_host.sv
// tb/tb_ghostbus_host.sv - directed self-checking bench for ghostbus_host
module tb_ghostbus_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] cmd_wdata = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic [23:0] gb_addr;
    logic [31:0] gb_dout;
    logic        gb_we;
    logic        gb_re;
    logic [31:0] gb_din = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ghostbus_host #(
        .AW(24), .DW(32), .LW(8), .RD_LAT(2), .RSP_DEPTH(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we), .gb_re(gb_re),
        .gb_din(gb_din), .busy(busy)
    );

    function automatic logic [31:0] resp_val(input logic [23:0] a);
        return (a == 24'h10) ? 32'h42 : {8'hD0, a};
    endfunction

    // Responder: data for an address read in cycle T is on gb_din in cycle T+2.
    logic [31:0] p1 = '0;
    always @(posedge clk) begin
        p1     <= gb_re ? resp_val(gb_addr) : 32'h0;
        gb_din <= p1;
    end

    task automatic send_cmd(input logic we, input logic [23:0] a, input logic [7:0] len,
                            input logic [31:0] wd);
        int n;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len; cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept got cmd_ready=%b want 1 within 50 cycles", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gb_we, gb_re, cmd_ready, wr_ready, rsp_valid, rsp_last, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {gb_we, gb_re, cmd_ready, wr_ready, rsp_valid, rsp_last, busy});
        end
        checks++;
        if (gb_addr !== 24'h0 || gb_dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h dout=%h want 0/0", gb_addr, gb_dout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_cmd_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_single_write();
        rsp_ready = 1'b1;
        send_cmd(1'b1, 24'h40, 8'd0, 32'h5);
        checks++;
        if (gb_we !== 1'b1 || gb_re !== 1'b0 || gb_addr !== 24'h40 || gb_dout !== 32'h5) begin
            errors++;
            $display("FAIL single_write got we=%b re=%b addr=%h dout=%h want 1 0 000040 00000005",
                     gb_we, gb_re, gb_addr, gb_dout);
        end
        @(negedge clk);
        checks++;
        if (gb_we !== 1'b0) begin
            errors++;
            $display("FAIL single_write_one_cycle got we=%b want 0", gb_we);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_write_no_rsp got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_single_read();
        send_cmd(1'b0, 24'h10, 8'd0, 32'h0);
        checks++;
        if (gb_re !== 1'b0) begin
            errors++;
            $display("FAIL single_read_early got re=%b want 0", gb_re);
        end
        @(negedge clk);
        checks++;
        if (gb_re !== 1'b1 || gb_addr !== 24'h10) begin
            errors++;
            $display("FAIL single_read_strobe got re=%b addr=%h want 1 000010", gb_re, gb_addr);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || gb_re !== 1'b0) begin
                errors++;
                $display("FAIL single_read_latency got rsp_valid=%b re=%b want 0 0", rsp_valid, gb_re);
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h42 || rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL single_read_rsp got valid=%b data=%h last=%b want 1 00000042 1",
                     rsp_valid, rsp_data, rsp_last);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_read_drain got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_read_burst();
        int issued;
        int popped;
        issued = 0;
        popped = 0;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 24'h40, 8'd7, 32'h0);
        for (int c = 0; c < 30; c++) begin
            if (gb_re) begin
                checks++;
                if (gb_addr !== 24'h40 + 24'(issued)) begin
                    errors++;
                    $display("FAIL burst_addr got %h want %h", gb_addr, 24'h40 + 24'(issued));
                end
                issued++;
            end
            @(negedge clk);
        end
        checks++;
        if (issued != 8 || rsp_valid !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL burst_issue got issued=%0d valid=%b busy=%b cmd_ready=%b want 8 1 1 1",
                     issued, rsp_valid, busy, cmd_ready);
        end
        for (int c = 0; c < 30; c++) begin
            rsp_ready = 1'b1;
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== {8'hD0, 24'h40 + 24'(popped)} || rsp_last !== (popped == 7)) begin
                    errors++;
                    $display("FAIL burst_rsp got data=%h last=%b want %h %b", rsp_data, rsp_last,
                             {8'hD0, 24'h40 + 24'(popped)}, popped == 7);
                end
                popped++;
            end
            @(negedge clk);
        end
        checks++;
        if (popped != 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_count got popped=%0d busy=%b want 8 0", popped, busy);
        end
    endtask

    task automatic test_backpressure();
        int issued;
        int popped;
        int c;
        issued = 0;
        popped = 0;
        c = 0;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 24'h100, 8'd9, 32'h0);
        while (popped < 10 && c < 200) begin
            if (gb_re) begin
                checks++;
                if (gb_addr !== 24'h100 + 24'(issued)) begin
                    errors++;
                    $display("FAIL bp_addr got %h want %h", gb_addr, 24'h100 + 24'(issued));
                end
                issued++;
                checks++;
                if (issued - popped > 8) begin
                    errors++;
                    $display("FAIL bp_credit got %0d in flight want <= 8", issued - popped);
                end
            end
            if (c == 20) begin
                checks++;
                if (issued != 8) begin
                    errors++;
                    $display("FAIL bp_stall got issued=%0d want 8", issued);
                end
            end
            rsp_ready = (c >= 20) ? c[0] : 1'b0;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_data !== {8'hD0, 24'h100 + 24'(popped)} || rsp_last !== (popped == 9)) begin
                    errors++;
                    $display("FAIL bp_rsp got data=%h last=%b want %h %b", rsp_data, rsp_last,
                             {8'hD0, 24'h100 + 24'(popped)}, popped == 9);
                end
                popped++;
            end
            @(negedge clk);
            c++;
        end
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (issued != 10 || popped != 10 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_total got issued=%0d popped=%0d valid=%b busy=%b want 10 10 0 0",
                     issued, popped, rsp_valid, busy);
        end
    endtask

    task automatic test_write_burst();
        logic        pat [8];
        logic [23:0] exp_a [4];
        int          beats;
        logic        exp_we;
        pat   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        beats = 1;
        wr_valid = 1'b0;
        send_cmd(1'b1, 24'hFFFFFE, 8'd3, 32'hA0);
        checks++;
        if (gb_we !== 1'b1 || gb_addr !== 24'hFFFFFE || gb_dout !== 32'hA0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wburst_first got we=%b addr=%h dout=%h wr_ready=%b want 1 fffffe 000000a0 1",
                     gb_we, gb_addr, gb_dout, wr_ready);
        end
        for (int k = 0; k < 8; k++) begin
            wr_valid = pat[k];
            wr_data  = 32'hB0 + 32'(k);
            @(negedge clk);
            exp_we = pat[k] && (beats < 4);
            checks++;
            if (gb_we !== exp_we || gb_re !== 1'b0) begin
                errors++;
                $display("FAIL wburst_we k=%0d got we=%b re=%b want %b 0", k, gb_we, gb_re, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (gb_addr !== exp_a[beats] || gb_dout !== 32'hB0 + 32'(k)) begin
                    errors++;
                    $display("FAIL wburst_beat got addr=%h dout=%h want %h %h",
                             gb_addr, gb_dout, exp_a[beats], 32'hB0 + 32'(k));
                end
                beats++;
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (beats != 4 || wr_ready !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wburst_end got beats=%0d wr_ready=%b cmd_ready=%b want 4 0 1",
                     beats, wr_ready, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        int c;
        seen = 0;
        c = 0;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 24'h200, 8'd7, 32'h0);
        while (seen < 3 && c < 20) begin
            if (gb_re) seen++;
            if (seen < 3) @(negedge clk);
            c++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (seen != 3 || {gb_we, gb_re, cmd_ready, wr_ready, rsp_valid, rsp_last, busy} !== 7'b0
            || gb_addr !== 24'h0 || gb_dout !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got seen=%0d ctrl=%b addr=%h dout=%h want 3 0000000 0 0", seen,
                     {gb_we, gb_re, cmd_ready, wr_ready, rsp_valid, rsp_last, busy}, gb_addr, gb_dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, gb_re, gb_we} !== 3'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet got valid/re/we=%b want 000", {rsp_valid, gb_re, gb_we});
            end
        end
        rsp_ready = 1'b1;
        send_cmd(1'b0, 24'h10, 8'd0, 32'h0);
        c = 0;
        while (!rsp_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h42 || rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_read got valid=%b data=%h last=%b want 1 00000042 1",
                     rsp_valid, rsp_data, rsp_last);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_read_burst();
        test_backpressure();
        test_write_burst();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
